// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, writeback select encoding and stage entry type
package pipe_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam logic [ADDR_W-1:0] RA_IDX  = 4'd15;
  localparam logic [DATA_W-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LD   = 2'd1,
    WB_CALL = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ld_result;
    logic              is_ld;
    logic              is_call;
    logic              is_wb;
  } rw_entry_t;

  // A call outranks a load when both flags are set.
  function automatic wb_sel_e wb_select(input logic is_call, input logic is_ld);
    if (is_call)    return WB_CALL;
    else if (is_ld) return WB_LD;
    else            return WB_ALU;
  endfunction
endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x32 architectural register file, one sync write port, two async read ports
module reg_file
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/rw_stage.sv
// rtl/rw_stage.sv - writeback stage: latches MA results, commits to the register file, bypasses reads
module rw_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ma_valid,
  input  logic [DATA_W-1:0] ma_pc,
  input  logic [ADDR_W-1:0] ma_rd,
  input  logic [DATA_W-1:0] ma_alu_result,
  input  logic [DATA_W-1:0] ma_ld_result,
  input  logic              ma_is_ld,
  input  logic              ma_is_call,
  input  logic              ma_is_wb,
  input  logic [ADDR_W-1:0] read_port1,
  input  logic [ADDR_W-1:0] read_port2,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] instret
);
  rw_entry_t         r_stage;
  logic [DATA_W-1:0] r_instret;
  rw_entry_t         w_next;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_rf_data1;
  logic [DATA_W-1:0] w_rf_data2;
  logic              w_wb_valid;
  logic [ADDR_W-1:0] w_wb_addr;

  // Data fields are captured even for bubbles; only control bits are squashed.
  always_comb begin
    w_next            = '0;
    w_next.valid      = ma_valid;
    w_next.pc         = ma_pc;
    w_next.rd         = ma_rd;
    w_next.alu_result = ma_alu_result;
    w_next.ld_result  = ma_ld_result;
    w_next.is_ld      = ma_valid & ma_is_ld;
    w_next.is_call    = ma_valid & ma_is_call;
    w_next.is_wb      = ma_valid & ma_is_wb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage   <= '0;
      r_instret <= '0;
    end else begin
      r_stage <= w_next;
      if (r_stage.valid) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_wb_data = r_stage.alu_result;
    case (wb_select(r_stage.is_call, r_stage.is_ld))
      WB_CALL: w_wb_data = r_stage.pc + PC_INCR;
      WB_LD:   w_wb_data = r_stage.ld_result;
      default: w_wb_data = r_stage.alu_result;
    endcase
  end

  assign w_wb_valid = r_stage.valid & (r_stage.is_wb | r_stage.is_call);
  assign w_wb_addr  = r_stage.is_call ? RA_IDX : r_stage.rd;

  reg_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_wb_valid),
    .i_waddr  (w_wb_addr),
    .i_wdata  (w_wb_data),
    .i_raddr1 (read_port1),
    .i_raddr2 (read_port2),
    .o_rdata1 (w_rf_data1),
    .o_rdata2 (w_rf_data2)
  );

  // Pending write is younger than anything in the array, so it wins on address match.
  assign op1 = (w_wb_valid && read_port1 == w_wb_addr) ? w_wb_data : w_rf_data1;
  assign op2 = (w_wb_valid && read_port2 == w_wb_addr) ? w_wb_data : w_rf_data2;

  assign wb_valid = w_wb_valid;
  assign wb_addr  = w_wb_addr;
  assign wb_data  = w_wb_data;
  assign instret  = r_instret;
endmodule
